i2c_cfg_master: RTL and testbench
=================================

# i2c_cfg_master

Single-transaction I2C write initiator for the FIR filter configuration path: drives SCL/SDA to send START, 7-bit device address + W, two data bytes (register index, value) and STOP, checking the target's ACK after each byte. Sits between the FIR control logic and the external I2C bus. It is the initiator side of the byte/bit framing the filter's I2C target decodes with its 3-bit bit counter.

## Interface
- QDIV, default 4: clk cycles per SCL quarter period; legal range 1..255.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_in  in  1  request a transaction; honoured only in IDLE.
- dev_addr_in  in  7  target address; latched on accept.
- byte0_in  in  8  first data byte (register index); latched on accept.
- byte1_in  in  8  second data byte (value); latched on accept.
- sda_in  in  1  sampled bus SDA level (ACK input).
- scl_out  out  1  SCL drive; 1 = released/high, 0 = pulled low.
- sda_out  out  1  SDA drive; 1 = released/high, 0 = pulled low.
- busy_out  out  1  high while a transaction is in progress.
- done_out  out  1  one-cycle pulse at transaction end.
- nack_out  out  1  sticky: at least one NACK in current/last transaction.

## Operation
- States: IDLE, START, ADDR, ACK_A, DATA0, ACK_0, DATA1, ACK_1, STOP.
- Quarter tick: divider counts 0..QDIV-1, tick on terminal count; divider held at 0 in IDLE. Each state step spans whole quarters; phase counter 0..3 per bit.
- Data bit (ADDR/DATA*): ph0 SCL=0, SDA=bit; ph1 SCL=0; ph2,ph3 SCL=1. SDA changes only in ph0.
- Shift order MSB first; ADDR sends dev_addr_in[6:0] then 0 (W) = 8 bits; 3-bit bit counter wraps 7→0 into the ACK state.
- ACK bit: SDA released (1); sda_in sampled on the last clk of ph2; 1 = NACK, sets nack_out.
- START: ph0,ph1 SCL=1 SDA=1; ph2,ph3 SCL=1 SDA=0.
- STOP: ph0 SCL=0 SDA=0; ph1 SCL=1 SDA=0; ph2,ph3 SCL=1 SDA=1; then IDLE.
- Accept: start_in=1 in IDLE latches inputs, clears nack_out, enters START. start_in outside IDLE ignored (no queueing).
- Reset values: scl_out=1, sda_out=1, busy_out=0, done_out=0, nack_out=0, state IDLE. Reset mid-transaction releases both lines asynchronously; no STOP generated.

## Timing
- Accept at edge k: busy_out=1 from k, START ph0 begins k.
- Full transaction = 4 + 27×4 + 4 = 116 quarters; done_out high for exactly the cycle at k+116·QDIV, same edge busy_out falls.
- start_in held high at the done edge is not accepted until the next cycle (IDLE for ≥1 cycle between transactions).
- nack_out stable from sampling edge until next accept.

## Configuration
- I2C_NACK_ABORT_EN defined: NACK in any ACK state goes to STOP after that ACK bit; address NACK ends in 4+9×4+4 = 44 quarters, DATA0 NACK in 80 quarters.
- Undefined: NACK only sets nack_out; all 27 bits always sent, 116 quarters.

## Test plan
- Reset: hold rst_n=0 → scl_out=1, sda_out=1, busy_out=0, done_out=0, nack_out=0; assert rst_n=0 mid-DATA0 → same values immediately.
- Full write, QDIV=4, dev 0x50, bytes 0x12, 0xA5, sda_in=0 on ACKs → SDA during SCL-high: 1010000 0 A 00010010 A 10100101 A; START/STOP edges correct; done_out pulse at 464 cycles; nack_out=0.
- Address NACK, sda_in=1 always, QDIV=4 → with I2C_NACK_ABORT_EN done at 176 cycles, nack_out=1; without, done at 464 cycles, nack_out=1.
- QDIV=1 boundary, dev 0x7F, bytes 0xFF, 0x00 → done at 116 cycles, bit stream 1111111 0 A 11111111 A 00000000 A.
- start_in pulsed mid-transaction and held high at done → ignored; next accept one cycle after done, nack_out cleared on that accept.
- Back-to-back: second transaction after first NACK → nack_out clears at accept, stays 0 with all ACKs.

Source files
------------

// File: rtl/i2c_cfg_master_if.sv
// i2c_cfg_master_if: request, status and SCL/SDA signals of the I2C configuration write initiator
interface i2c_cfg_master_if;
  logic       start_in;
  logic [6:0] dev_addr_in;
  logic [7:0] byte0_in;
  logic [7:0] byte1_in;
  logic       sda_in;
  logic       scl_out;
  logic       sda_out;
  logic       busy_out;
  logic       done_out;
  logic       nack_out;
  modport master (
    input  start_in, dev_addr_in, byte0_in, byte1_in, sda_in,
    output scl_out, sda_out, busy_out, done_out, nack_out
  );
  modport slave (
    output start_in, dev_addr_in, byte0_in, byte1_in, sda_in,
    input  scl_out, sda_out, busy_out, done_out, nack_out
  );
endinterface

// File: rtl/i2c_cfg_master.sv
// i2c_cfg_master: one I2C write (START, addr+W, two bytes, STOP) with ACK checks.
// Define I2C_NACK_ABORT_EN to jump to STOP after any NACKed byte.
module i2c_cfg_master #(
  parameter int QDIV = 4
) (
  input logic              clk,
  input logic              rst_n,
  i2c_cfg_master_if.master bus
);
  typedef enum logic [3:0] {IDLE, START, ADDR, ACK_A, DATA0, ACK_0, DATA1, ACK_1, STOP} state_t;
`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  localparam logic [7:0] DMAX = 8'(QDIV - 1);
  state_t     state;
  logic [7:0] div, sh, b0, b1;
  logic [1:0] ph;
  logic [2:0] bit_cnt;
  logic       ack_bad;
  logic       tick, is_data, is_ack;
  assign tick    = state != IDLE && div == DMAX;
  assign is_data = state inside {ADDR, DATA0, DATA1};
  assign is_ack  = state inside {ACK_A, ACK_0, ACK_1};
  // Outputs are set on the tick that enters a phase, so they always show the current phase.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      ph           <= '0;
      bit_cnt      <= '0;
      sh           <= '0;
      b0           <= '0;
      b1           <= '0;
      ack_bad      <= 1'b0;
      bus.scl_out  <= 1'b1;
      bus.sda_out  <= 1'b1;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.nack_out <= 1'b0;
    end else begin
      bus.done_out <= 1'b0;
      div <= (state == IDLE || tick) ? '0 : div + 8'd1;
      if (state == IDLE) begin
        if (bus.start_in) begin
          state        <= START;
          ph           <= '0;
          bit_cnt      <= '0;
          sh           <= {bus.dev_addr_in, 1'b0};
          b0           <= bus.byte0_in;
          b1           <= bus.byte1_in;
          bus.busy_out <= 1'b1;
          bus.nack_out <= 1'b0;
        end
      end else if (tick) begin
        ph <= ph + 2'd1;
        case (ph)
          2'd0: if (state == STOP) bus.scl_out <= 1'b1;
          2'd1: begin
            bus.scl_out <= 1'b1;
            bus.sda_out <= state == START ? 1'b0 : state == STOP ? 1'b1 : bus.sda_out;
          end
          2'd2: if (is_ack) begin
            ack_bad <= bus.sda_in;
            if (bus.sda_in) bus.nack_out <= 1'b1;
          end
          default: begin
            bus.scl_out <= state == STOP;
            if (state == START) begin
              state       <= ADDR;
              bus.sda_out <= sh[7];
            end else if (is_data) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // sh now preloads the byte that follows this ACK
                state       <= state == ADDR ? ACK_A : state == DATA0 ? ACK_0 : ACK_1;
                sh          <= state == ADDR ? b0 : b1;
                bus.sda_out <= 1'b1;
              end else begin
                sh          <= sh << 1;
                bus.sda_out <= sh[6];
              end
            end else if (is_ack) begin
              if (state == ACK_1 || (ABORT && ack_bad)) begin
                state       <= STOP;
                bus.sda_out <= 1'b0;
              end else begin
                state       <= state == ACK_A ? DATA0 : DATA1;
                bus.sda_out <= sh[7];
              end
            end else begin
              state        <= IDLE;
              bus.busy_out <= 1'b0;
              bus.done_out <= 1'b1;
            end
          end
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_cfg_master.sv
// tb_i2c_cfg_master: scoreboard bench running i2c_cfg_master at QDIV=4 and QDIV=1 side by side,
// checking the SDA-at-SCL-rise stream, START/STOP framing, duration and NACK flag per transaction.
module tb_i2c_cfg_master;
  typedef struct {
    logic [6:0] dev;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [2:0] plan;
    int         mode;
  } txn_t;
  typedef struct {
    logic [31:0] bits;
    int          n;
    int          cyc;
    logic        nack;
  } exp_t;
  logic clk = 1'b0;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  task automatic chk(input int q, input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL q%0d %s: got %0h expected %0h at %0t", q, name, act, want, $time);
    end
  endtask
  // Every byte is followed by a released ACK bit; the SCL rise before STOP sees SDA low.
  function automatic exp_t model(input txn_t t, input int q);
    exp_t e;
    logic [7:0] by [3];
    by[0] = {t.dev, 1'b0};
    by[1] = t.b0;
    by[2] = t.b1;
    e.bits = '0;
    e.n = 0;
    e.nack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 7; j >= 0; j--) begin
        e.bits = {e.bits[30:0], by[k][j]};
        e.n++;
      end
      e.bits = {e.bits[30:0], 1'b1};
      e.n++;
      if (t.plan[k]) e.nack = 1'b1;
`ifdef I2C_NACK_ABORT_EN
      if (t.plan[k]) break;
`endif
    end
    e.cyc = (8 + 4 * e.n) * q;
    e.bits = {e.bits[30:0], 1'b0};
    e.n++;
    return e;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int Q = g == 0 ? 4 : 1;
    logic rst_n;
    bit fin = 1'b0;
    exp_t exp_q[$];
    logic [2:0] plan_q[$];
    i2c_cfg_master_if ifc ();
    i2c_cfg_master #(.QDIV(Q)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
    // Monitor and ACK responder: decodes the bus, answers ACK slots, scores each done pulse.
    initial begin
      logic pscl, psda, pbusy, pdone, active;
      logic [2:0] plan;
      logic [31:0] bits;
      int cnt, nbits, starts, stops;
      exp_t e;
      {pscl, psda, pbusy, pdone, active} = 5'b11000;
      plan = '0;
      bits = '0;
      cnt = 0;
      nbits = 0;
      starts = 0;
      stops = 0;
      ifc.sda_in = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          {pscl, psda, pbusy, pdone, active} = 5'b11000;
          continue;
        end
        if (ifc.busy_out && !pbusy) begin
          active = 1'b1;
          cnt = 0;
          nbits = 0;
          bits = '0;
          starts = 0;
          stops = 0;
        end else cnt++;
        if (active) begin
          if (pscl && ifc.scl_out && psda && !ifc.sda_out) begin
            starts++;
            plan = plan_q.size() > 0 ? plan_q.pop_front() : 3'b000;
          end
          if (pscl && ifc.scl_out && !psda && ifc.sda_out) stops++;
          if (!pscl && ifc.scl_out) begin
            bits = {bits[30:0], ifc.sda_out};
            nbits++;
            if (nbits % 9 == 0 && nbits <= 27) ifc.sda_in = plan[nbits / 9 - 1];
          end
          if (pscl && !ifc.scl_out) ifc.sda_in = 1'($urandom);
        end
        if (ifc.done_out) begin
          chk(Q, "done_width", pdone, 1'b0);
          chk(Q, "done_in_txn", active, 1'b1);
          chk(Q, "sb_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(Q, "cycles", cnt, e.cyc);
            chk(Q, "bit_count", nbits, e.n);
            chk(Q, "bit_stream", bits, e.bits);
            chk(Q, "nack", ifc.nack_out, e.nack);
            chk(Q, "busy_at_done", ifc.busy_out, 1'b0);
            chk(Q, "starts", starts, 1);
            chk(Q, "stops", stops, 1);
          end
          active = 1'b0;
        end
        pscl = ifc.scl_out;
        psda = ifc.sda_out;
        pbusy = ifc.busy_out;
        pdone = ifc.done_out;
      end
    end
    initial begin
      txn_t tl[$];
      txn_t t, n;
      exp_t e;
      bit pre;
      rst_n = 1'b0;
      ifc.start_in = 1'b0;
      {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = '0;
      repeat (3) @(negedge clk);
      chk(Q, "reset_outs", {ifc.scl_out, ifc.sda_out, ifc.busy_out, ifc.done_out, ifc.nack_out}, 5'b11000);
      rst_n = 1'b1;
      tl.push_back('{7'h50, 8'h12, 8'hA5, 3'b000, 0});
      tl.push_back('{7'h2C, 8'h3C, 8'h5A, 3'b111, 1});
      tl.push_back('{7'h7F, 8'hFF, 8'h00, 3'b000, 0});
      tl.push_back('{7'h15, 8'h81, 8'h7E, 3'b010, 0});
      tl.push_back('{7'h01, 8'h02, 8'h03, 3'b100, 0});
      tl.push_back('{7'h33, 8'h44, 8'h55, 3'b000, 2});
      for (int k = 0; k < 8; k++) begin
        t.dev = 7'($urandom);
        t.b0 = 8'($urandom);
        t.b1 = 8'($urandom);
        t.plan = $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'b000;
        t.mode = 0;
        tl.push_back(t);
      end
      pre = 1'b0;
      for (int i = 0; i < tl.size(); i++) begin
        t = tl[i];
        e = model(t, Q);
        if (!pre) begin
          for (int c = 0; c < 1000 * Q && ifc.busy_out; c++) @(negedge clk);
          chk(Q, "idle_wait", ifc.busy_out, 1'b0);
          @(negedge clk);
          {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = {t.dev, t.b0, t.b1};
          plan_q.push_back(t.plan);
          exp_q.push_back(e);
          ifc.start_in = 1'b1;
          @(negedge clk);
          ifc.start_in = 1'b0;
          {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = 23'($urandom);
        end
        pre = 1'b0;
        if (t.mode == 1 && i + 1 < tl.size()) begin
          repeat (10 * Q) @(negedge clk);
          ifc.start_in = 1'b1;
          {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = 23'($urandom);
          @(negedge clk);
          ifc.start_in = 1'b0;
          repeat (e.cyc - 10 * Q - 4) @(negedge clk);
          n = tl[i + 1];
          {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = {n.dev, n.b0, n.b1};
          plan_q.push_back(n.plan);
          exp_q.push_back(model(n, Q));
          ifc.start_in = 1'b1;
          for (int c = 0; c < 8 && !ifc.done_out; c++) @(negedge clk);
          chk(Q, "done_when_due", ifc.done_out, 1'b1);
          @(negedge clk);
          chk(Q, "reaccept_busy_nack", {ifc.busy_out, ifc.nack_out}, 2'b10);
          ifc.start_in = 1'b0;
          {ifc.dev_addr_in, ifc.byte0_in, ifc.byte1_in} = 23'($urandom);
          pre = 1'b1;
        end else if (t.mode == 2) begin
          repeat (56 * Q - 1) @(negedge clk);
          #1 rst_n = 1'b0;
          #1 chk(Q, "async_reset_outs", {ifc.scl_out, ifc.sda_out, ifc.busy_out, ifc.done_out, ifc.nack_out}, 5'b11000);
          exp_q.delete();
          plan_q.delete();
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      for (int c = 0; c < 1000 * Q && ifc.busy_out; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk(Q, "sb_drained", exp_q.size(), 0);
      fin = 1'b1;
    end
  end
  initial begin
    for (int c = 0; c < 80000 && !(inst[0].fin && inst[1].fin); c++) @(posedge clk);
    if (!(inst[0].fin && inst[1].fin)) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: stimulus did not complete within the cycle budget");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
